// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
// dvp_pkg
// Shared types and RGB565 colour constants for the DVP test-pattern source.
// Revision: 1.0
// ============================================================================
package dvp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_CHECK = 2'd3
    } pat_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Bars past the eighth (non-multiple-of-8 widths) fall into the black bar.
    function automatic logic [15:0] bar_colour(input logic [15:0] idx);
        logic [15:0] c;
        case (idx)
            16'd0:   c = RGB_WHITE;
            16'd1:   c = RGB_YELLOW;
            16'd2:   c = RGB_CYAN;
            16'd3:   c = RGB_GREEN;
            16'd4:   c = RGB_MAGENTA;
            16'd5:   c = RGB_RED;
            16'd6:   c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pattern_gen.sv
`default_nettype none
// ============================================================================
// dvp_pattern_gen
// Combinational (x, y, frame_cnt, pattern) -> RGB565 pixel mapping.
// Revision: 1.0
// ============================================================================
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_PIXEL = 640
) (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [7:0]  i_frame_cnt,
    input  pat_e        i_pattern,
    input  logic [15:0] i_solid_rgb,
    output logic [15:0] o_pixel
);

    localparam int BAR_W = ((H_PIXEL / 8) > 0) ? (H_PIXEL / 8) : 1;

    logic [15:0] w_bar_idx;

    always_comb begin
        w_bar_idx = i_x / 16'(BAR_W);
        o_pixel   = RGB_BLACK;
        case (i_pattern)
            PAT_BARS:  o_pixel = bar_colour(w_bar_idx);
            PAT_RAMP:  o_pixel = i_x;
            PAT_SOLID: o_pixel = i_solid_rgb;
            PAT_CHECK: o_pixel = (i_x[4] ^ i_y[4] ^ i_frame_cnt[0]) ? RGB_WHITE : RGB_BLACK;
            default:   o_pixel = RGB_BLACK;
        endcase
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{i_y[15:5], i_y[3:0], i_frame_cnt[7:1]};

endmodule
`default_nettype wire

// File: rtl/dvp_pattern_tx.sv
`default_nettype none
// ============================================================================
// dvp_pattern_tx
// DVP (vsync/href/8-bit data) test-pattern transmitter, RGB565 two bytes/pixel.
// Revision: 1.0
// ============================================================================
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_PIXEL   = 640,
    parameter int V_PIXEL   = 480,
    parameter int H_BLANK   = 288,
    parameter int VS_LINES  = 4,
    parameter int VBP_LINES = 18,
    parameter int VFP_LINES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid_rgb,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int H_TOTAL = 2 * H_PIXEL + H_BLANK;
    localparam int V_TOTAL = VS_LINES + VBP_LINES + V_PIXEL + VFP_LINES;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END   = HW'(2 * H_PIXEL);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(VS_LINES);
    localparam logic [VW-1:0] V_ACT_START = VW'(VS_LINES + VBP_LINES);
    localparam logic [VW-1:0] V_ACT_END   = VW'(VS_LINES + VBP_LINES + V_PIXEL);

    state_e      state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    pat_e        pat_q, pat_d;
    logic [15:0] solid_q, solid_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;

    logic        w_frame_start;
    logic        w_run;
    logic [15:0] w_pixel;

    // Sequencing: counters always point at the position being shown next cycle.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        pat_d         = pat_q;
        solid_d       = solid_q;
        w_frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_en) begin
                    state_d       = ST_RUN;
                    h_cnt_d       = '0;
                    v_cnt_d       = '0;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d     = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        if (tx_en) begin
                            w_frame_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_frame_start) begin
            pat_d   = pat_e'(pat_sel);
            solid_d = solid_rgb;
        end
    end

    dvp_pattern_gen #(
        .H_PIXEL (H_PIXEL)
    ) u_gen (
        .i_x         (16'(h_cnt_d >> 1)),
        .i_y         (16'(v_cnt_d - V_ACT_START)),
        .i_frame_cnt (frame_cnt_d),
        .i_pattern   (pat_d),
        .i_solid_rgb (solid_d),
        .o_pixel     (w_pixel)
    );

    // Outputs are decoded from the next position so they line up with it.
    always_comb begin
        w_run        = (state_d == ST_RUN);
        vsync_d      = w_run && (v_cnt_d < V_SYNC_END);
        href_d       = w_run && (v_cnt_d >= V_ACT_START) && (v_cnt_d < V_ACT_END)
                       && (h_cnt_d < H_ACT_END);
        data_d       = href_d ? (h_cnt_d[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
        frame_done_d = w_run && (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
        busy_d       = w_run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_cnt_q  <= '0;
            pat_q        <= PAT_BARS;
            solid_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            pat_q        <= pat_d;
            solid_q      <= solid_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign dvp_data   = data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire
